// File: rtl/float_to_fix_pipe.sv
// float_to_fix_pipe: 3-stage float to signed fixed-point converter with RTZ/RNE rounding and saturation
//   clk_i, rst_i                  clock, synchronous active-high reset
//   s_valid_i/s_ready_o           operand handshake; s_float_i {sign,exp,man}, s_rnd_mode_i 0=RTZ 1=RNE
//   m_valid_o/m_ready_i           result handshake; m_fixed_o signed FIXED_WIDTH result
//   m_nan_o, m_snan_o, m_inf_o    input class flags
//   m_ovf_o, m_inexact_o          finite-input saturation, discarded nonzero fraction
module float_to_fix_pipe #(
    parameter int EXP_WIDTH   = 5,
    parameter int MAN_WIDTH   = 10,
    parameter int FIXED_WIDTH = 40,
    parameter int FRAC_BITS   = 16,
    parameter int FLOAT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [FLOAT_WIDTH-1:0] s_float_i,
    input  logic                   s_rnd_mode_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [FIXED_WIDTH-1:0] m_fixed_o,
    output logic                   m_nan_o,
    output logic                   m_snan_o,
    output logic                   m_inf_o,
    output logic                   m_ovf_o,
    output logic                   m_inexact_o
);
    localparam int BIAS  = (1 << (EXP_WIDTH - 1)) - 1;
    localparam int SW    = MAN_WIDTH + 1;
    localparam int SHMAX = BIAS + FRAC_BITS - MAN_WIDTH;
    // largest left-shifted significand plus a carry bit, never narrower than the saturation compare
    localparam int MW0   = MAN_WIDTH + 2 + (SHMAX > 0 ? SHMAX : 0);
    localparam int MW    = MW0 > FIXED_WIDTH + 1 ? MW0 : FIXED_WIDTH + 1;
    localparam logic [MW-1:0] LIM = MW'(1) << (FIXED_WIDTH - 1);

    logic                   v1_q, sign1_q, nan1_q, snan1_q, inf1_q, rnd1_q;
    logic [SW-1:0]          sig1_q;
    logic signed [31:0]     sh1_q;
    logic                   v2_q, sign2_q, nan2_q, snan2_q, inf2_q, inex2_q;
    logic [MW-1:0]          mag2_q;
    logic                   v3_q, nan3_q, snan3_q, inf3_q, ovf3_q, inex3_q;
    logic [FIXED_WIDTH-1:0] fix3_q;

    logic                   ld1, ld2, ld3;
    logic [EXP_WIDTH-1:0]   e_f;
    logic [MAN_WIDTH-1:0]   m_f;
    logic                   e_max, e_zero, nan_d, snan_d, inf_d;
    logic [SW-1:0]          sig_d;
    logic signed [31:0]     sh_d, nsh;
    logic [31:0]            rs;
    logic [SW:0]            t;
    logic                   g, st, inc, inex_d;
    logic [MW-1:0]          mag_d;
    logic                   big, spec, ovf_d, inex3_d;
    logic [FIXED_WIDTH-1:0] mag_t, sat, fix_d;

    assign ld3       = !v3_q || m_ready_i;
    assign ld2       = !v2_q || ld3;
    assign ld1       = !v1_q || ld2;
    assign s_ready_o = ld1;

    always_comb begin
        e_f    = s_float_i[FLOAT_WIDTH-2 -: EXP_WIDTH];
        m_f    = s_float_i[MAN_WIDTH-1:0];
        e_max  = &e_f;
        e_zero = e_f == '0;
        nan_d  = e_max && |m_f;
        snan_d = nan_d && !m_f[MAN_WIDTH-1];
        inf_d  = e_max && m_f == '0;
        sig_d  = {!e_zero, m_f};
        sh_d   = (e_zero ? 32'sd1 : $signed(32'(e_f))) - BIAS + FRAC_BITS - MAN_WIDTH;
    end

    // Right shifts beyond the significand collapse to "everything is sticky"
    always_comb begin
        nsh    = -sh1_q;
        rs     = nsh > SW + 1 ? 32'(SW + 1) : nsh;
        t      = {sig1_q, 1'b0} >> rs;
        g      = t[0];
        st     = |({sig1_q, 1'b0} & ~({(SW + 1){1'b1}} << rs));
        inc    = rnd1_q && g && (st || t[1]);
        mag_d  = sh1_q >= 0 ? MW'(sig1_q) << sh1_q : MW'(t[SW:1]) + MW'(inc);
        inex_d = sh1_q < 0 && (g || st);
    end

    // Magnitude exactly 2^(FIXED_WIDTH-1) is representable only when negative
    always_comb begin
        spec    = nan2_q || inf2_q;
        big     = sign2_q ? mag2_q > LIM : mag2_q > LIM - 1'b1;
        ovf_d   = !spec && big;
        inex3_d = !spec && inex2_q;
        mag_t   = mag2_q[FIXED_WIDTH-1:0];
        sat     = sign2_q ? {1'b1, {(FIXED_WIDTH - 1){1'b0}}} : {1'b0, {(FIXED_WIDTH - 1){1'b1}}};
        fix_d   = nan2_q ? '0 : (inf2_q || big) ? sat : sign2_q ? -mag_t : mag_t;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q <= 1'b0; sign1_q <= 1'b0; nan1_q <= 1'b0; snan1_q <= 1'b0; inf1_q <= 1'b0;
            rnd1_q <= 1'b0; sig1_q <= '0; sh1_q <= '0;
            v2_q <= 1'b0; sign2_q <= 1'b0; nan2_q <= 1'b0; snan2_q <= 1'b0; inf2_q <= 1'b0;
            inex2_q <= 1'b0; mag2_q <= '0;
            v3_q <= 1'b0; nan3_q <= 1'b0; snan3_q <= 1'b0; inf3_q <= 1'b0; ovf3_q <= 1'b0;
            inex3_q <= 1'b0; fix3_q <= '0;
        end else begin
            if (ld1) begin
                v1_q <= s_valid_i;
                if (s_valid_i) begin
                    sign1_q <= s_float_i[FLOAT_WIDTH-1];
                    nan1_q  <= nan_d;
                    snan1_q <= snan_d;
                    inf1_q  <= inf_d;
                    rnd1_q  <= s_rnd_mode_i;
                    sig1_q  <= sig_d;
                    sh1_q   <= sh_d;
                end
            end
            if (ld2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    sign2_q <= sign1_q;
                    nan2_q  <= nan1_q;
                    snan2_q <= snan1_q;
                    inf2_q  <= inf1_q;
                    mag2_q  <= mag_d;
                    inex2_q <= inex_d;
                end
            end
            if (ld3) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    fix3_q  <= fix_d;
                    nan3_q  <= nan2_q;
                    snan3_q <= snan2_q;
                    inf3_q  <= inf2_q;
                    ovf3_q  <= ovf_d;
                    inex3_q <= inex3_d;
                end
            end
        end
    end

    assign m_valid_o   = v3_q;
    assign m_fixed_o   = fix3_q;
    assign m_nan_o     = nan3_q;
    assign m_snan_o    = snan3_q;
    assign m_inf_o     = inf3_q;
    assign m_ovf_o     = ovf3_q;
    assign m_inexact_o = inex3_q;
endmodule
